// File: rtl/fir_mac_nch.sv
// fir_mac_nch: parametrised multi-channel FIR multiply-accumulate engine
//
// All channels share one coefficient stream. The coefficients come from an
// external ROM that has one cycle of read latency. A sequence starts when
// `sequencing` rises and ends when it falls. Two cycles after the fall the
// engine registers one result per channel and pulses out_vld for one cycle.
//
// Optional build macro:
//   FIR_SAT_EN  when defined, the shifted accumulator saturates to the signed
//               DW range. When undefined, the result is the low DW bits, which
//               wrap in two's complement.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   sequencing  high while the queues stream one sample per cycle
//   smpl_in     packed signed samples, channel k in [k*DW +: DW]
//   coeff_in    signed coefficient, valid one cycle after coeff_addr
//   coeff_addr  coefficient ROM read address
//   smpl_out    registered packed results, held between out_vld pulses
//   out_vld     one-cycle pulse when smpl_out updates
//   busy        high while a sequence is accumulating
//   ovr         sticky tap-overrun flag, cleared at the next sequence start
module fir_mac_nch #(
    parameter int NCH   = 2,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int ACCW  = 40,
    parameter int AW    = 10,
    parameter int NTAPS = 1021,
    parameter int SHIFT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sequencing,
    input  logic [NCH*DW-1:0] smpl_in,
    input  logic [CW-1:0]     coeff_in,
    output logic [AW-1:0]     coeff_addr,
    output logic [NCH*DW-1:0] smpl_out,
    output logic              out_vld,
    output logic              busy,
    output logic              ovr
);
    typedef enum logic [1:0] {IDLE, SEQ, DONE} state_t;

    localparam int CNTW = $clog2(NTAPS + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);

    state_t                 state, state_nx;
    logic [CNTW-1:0]        mac_cnt;
    logic                   start, at_end, mac_en;
    logic signed [ACCW-1:0] coeff_x;
    logic [NCH*DW-1:0]      result;

    // A start from IDLE, or directly from DONE, only clears the accumulators
    // and requests address 1. The coefficient for address 0 is still in the ROM.
    assign busy    = state == SEQ;
    assign start   = sequencing && state != SEQ;
    assign at_end  = mac_cnt == CNTW'(NTAPS);
    assign mac_en  = busy && sequencing && !at_end;
    assign coeff_x = {{(ACCW-CW){coeff_in[CW-1]}}, coeff_in};

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = (busy && !sequencing) ? DONE : sequencing ? SEQ : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coeff_addr <= '0;
            mac_cnt    <= '0;
            ovr        <= 1'b0;
            out_vld    <= 1'b0;
            smpl_out   <= '0;
        end else begin
            out_vld <= state == DONE;
            if (state == DONE) smpl_out <= result;
            mac_cnt <= start ? '0 : mac_en ? mac_cnt + CNTW'(1) : mac_cnt;
            ovr     <= !start && (ovr || (busy && sequencing && at_end));
            // The address stops at the last tap. The final coefficient is then
            // still on coeff_in when the last MAC uses it.
            if (start)
                coeff_addr <= AW'(1);
            else if (busy && !sequencing)
                coeff_addr <= '0;
            else if (mac_en && coeff_addr < LAST_ADDR)
                coeff_addr <= coeff_addr + AW'(1);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [ACCW-1:0] acc, smpl_x, prod;
        assign smpl_x = {{(ACCW-DW){smpl_in[k*DW+DW-1]}}, smpl_in[k*DW +: DW]};
        assign prod   = coeff_x * smpl_x;

        always_ff @(posedge clk or posedge rst)
            if (rst)         acc <= '0;
            else if (start)  acc <= '0;
            else if (mac_en) acc <= acc + prod;

`ifdef FIR_SAT_EN
        logic signed [ACCW-1:0] shd;
        logic [ACCW-DW:0]       hi;
        assign shd = acc >>> SHIFT;
        // The value fits in DW bits only when every bit from DW-1 upward matches the sign bit.
        assign hi  = shd[ACCW-1:DW-1];
        assign result[k*DW +: DW] =
            (!hi[ACCW-DW] && |hi)   ? {1'b0, {(DW-1){1'b1}}} :
            (hi[ACCW-DW] && !(&hi)) ? {1'b1, {(DW-1){1'b0}}} :
                                      shd[DW-1:0];
`else
        assign result[k*DW +: DW] = DW'(acc >>> SHIFT);
`endif
    end
endmodule

// File: tb/tb_fir_mac_nch.sv
// tb_fir_mac_nch: directed self-checking bench for fir_mac_nch
module tb_fir_mac_nch;
    localparam int NCH = 2, DW = 16, CW = 16, ACCW = 40, AW = 10, NTAPS = 8, SHIFT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              sequencing = 1'b0;
    logic [NCH*DW-1:0] smpl_in = '0;
    logic [CW-1:0]     coeff_in = '0;
    logic [AW-1:0]     coeff_addr;
    logic [NCH*DW-1:0] smpl_out;
    logic              out_vld, busy, ovr;

    logic [CW-1:0]     rom [0:1023];
    int                errors = 0, checks = 0;
    int                nvld, lat;
    logic [NCH*DW-1:0] res;
    logic [AW-1:0]     addr_tr [0:31];
    logic              ovr_tr  [0:31];
    logic              busy_tr [0:31];

    fir_mac_nch #(.NCH(NCH), .DW(DW), .CW(CW), .ACCW(ACCW), .AW(AW),
                  .NTAPS(NTAPS), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
        .coeff_in(coeff_in), .coeff_addr(coeff_addr), .smpl_out(smpl_out),
        .out_vld(out_vld), .busy(busy), .ovr(ovr)
    );

    always #5 clk = ~clk;

    // ROM model with a registered read: one cycle of latency.
    always @(posedge clk) coeff_in <= rom[coeff_addr];

    task automatic fill_rom(input logic [CW-1:0] v);
        for (int i = 0; i < 1024; i++) rom[i] = v;
    endtask

    // Holds sequencing high for n negedges, then low. Records the trace and any out_vld pulses.
    task automatic run_seq(input int n);
        nvld = 0; lat = -1; res = '0;
        @(negedge clk);
        addr_tr[0] = coeff_addr; ovr_tr[0] = ovr; busy_tr[0] = busy;
        sequencing = 1'b1;
        for (int i = 1; i <= n + 8; i++) begin
            @(negedge clk);
            addr_tr[i] = coeff_addr; ovr_tr[i] = ovr; busy_tr[i] = busy;
            if (i == n) sequencing = 1'b0;
            if (out_vld) begin
                nvld++;
                if (lat < 0) lat = i - n;
                res = smpl_out;
            end
        end
    endtask

    task automatic test_reset;
        logic vld_seen = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sequencing = ~sequencing;
            if (out_vld) vld_seen = 1'b1;
        end
        @(negedge clk);
        if (out_vld) vld_seen = 1'b1;
        checks++; if (smpl_out !== '0) begin errors++; $display("FAIL reset_smpl_out: got %h expected 0", smpl_out); end
        checks++; if (coeff_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", coeff_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
        checks++; if (vld_seen !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld_seen); end
        sequencing = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [AW-1:0] exp_a [0:6] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd0};
        fill_rom(16'h4000);
        smpl_in = {16'h2000, 16'h2000};
        run_seq(5);
        checks++; if (nvld !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", nvld); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        checks++; if (res !== 32'h4000_4000) begin errors++; $display("FAIL basic_result: got %h expected 40004000", res); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (addr_tr[i] !== exp_a[i]) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, addr_tr[i], exp_a[i]); end
        end
        checks++; if (busy_tr[2] !== 1'b1) begin errors++; $display("FAIL basic_busy_seq: got %b expected 1", busy_tr[2]); end
        checks++; if (busy_tr[8] !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", busy_tr[8]); end
        repeat (3) @(negedge clk);
        checks++; if (smpl_out !== 32'h4000_4000) begin errors++; $display("FAIL basic_hold: got %h expected 40004000", smpl_out); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_low: got %b expected 0", out_vld); end
    endtask

    task automatic test_channels;
        fill_rom(16'h4000);
        smpl_in = {16'hE000, 16'h2000};
        run_seq(5);
        checks++; if (res !== 32'hC000_4000) begin errors++; $display("FAIL channels_result: got %h expected c0004000", res); end
        checks++; if (nvld !== 1) begin errors++; $display("FAIL channels_pulses: got %0d expected 1", nvld); end
    endtask

    task automatic test_saturation;
        logic [NCH*DW-1:0] exp;
`ifdef FIR_SAT_EN
        exp = {16'h8000, 16'h7FFF};
`else
        exp = {16'h0007, 16'hFFF8};
`endif
        fill_rom(16'h7FFF);
        smpl_in = {16'h8001, 16'h7FFF};
        run_seq(5);
        checks++; if (res !== exp) begin errors++; $display("FAIL saturation_result: got %h expected %h", res, exp); end
    endtask

    task automatic test_zero_mac;
        fill_rom(16'h4000);
        smpl_in = {16'h2000, 16'h2000};
        run_seq(1);
        checks++; if (nvld !== 1) begin errors++; $display("FAIL zero_pulses: got %0d expected 1", nvld); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", lat); end
        checks++; if (res !== '0) begin errors++; $display("FAIL zero_result: got %h expected 0", res); end
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 1024; i++) rom[i] = (i < 8) ? 16'(2048 * (i + 1)) : 16'h7FFF;
        smpl_in = {16'hFF00, 16'h0100};
        run_seq(12);
        checks++; if (res !== 32'hFDC0_0240) begin errors++; $display("FAIL overrun_result: got %h expected fdc00240", res); end
        checks++; if (addr_tr[8] !== 10'd7) begin errors++; $display("FAIL overrun_addr_hold8: got %0d expected 7", addr_tr[8]); end
        checks++; if (addr_tr[12] !== 10'd7) begin errors++; $display("FAIL overrun_addr_hold12: got %0d expected 7", addr_tr[12]); end
        checks++; if (ovr_tr[8] !== 1'b0) begin errors++; $display("FAIL overrun_ovr_early: got %b expected 0", ovr_tr[8]); end
        checks++; if (ovr_tr[12] !== 1'b1) begin errors++; $display("FAIL overrun_ovr_set: got %b expected 1", ovr_tr[12]); end
        checks++; if (ovr_tr[20] !== 1'b1) begin errors++; $display("FAIL overrun_ovr_sticky: got %b expected 1", ovr_tr[20]); end
        run_seq(1);
        checks++; if (ovr_tr[0] !== 1'b1) begin errors++; $display("FAIL overrun_ovr_before: got %b expected 1", ovr_tr[0]); end
        checks++; if (ovr_tr[1] !== 1'b0) begin errors++; $display("FAIL overrun_ovr_clear: got %b expected 0", ovr_tr[1]); end
    endtask

    task automatic test_back_to_back;
        int                pulses = 0;
        int                p_at [0:1] = '{-1, -1};
        logic [NCH*DW-1:0] p_val [0:1] = '{'0, '0};
        logic              busy7 = 1'b0;
        fill_rom(16'h4000);
        smpl_in = {16'h2000, 16'h2000};
        @(negedge clk); sequencing = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk); sequencing = 1'b0;
        @(negedge clk); sequencing = 1'b1; smpl_in = {16'h1000, 16'h1000};
        for (int i = 7; i <= 16; i++) begin
            @(negedge clk);
            if (i == 7) busy7 = busy;
            if (i == 9) sequencing = 1'b0;
            if (out_vld) begin
                if (pulses < 2) begin p_at[pulses] = i; p_val[pulses] = smpl_out; end
                pulses++;
            end
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (p_at[0] !== 7 || p_at[1] !== 11) begin errors++; $display("FAIL b2b_timing: got %0d,%0d expected 7,11", p_at[0], p_at[1]); end
        checks++; if (p_val[0] !== 32'h4000_4000) begin errors++; $display("FAIL b2b_first: got %h expected 40004000", p_val[0]); end
        checks++; if (p_val[1] !== 32'h1000_1000) begin errors++; $display("FAIL b2b_second: got %h expected 10001000", p_val[1]); end
        checks++; if (busy7 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy7); end
    endtask

    task automatic test_abort;
        logic vld_seen = 1'b0;
        fill_rom(16'h4000);
        smpl_in = {16'h2000, 16'h2000};
        @(negedge clk); sequencing = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (smpl_out !== '0) begin errors++; $display("FAIL abort_smpl_out: got %h expected 0", smpl_out); end
        checks++; if (coeff_addr !== '0) begin errors++; $display("FAIL abort_addr: got %0d expected 0", coeff_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        sequencing = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_vld) vld_seen = 1'b1;
        end
        checks++; if (vld_seen !== 1'b0) begin errors++; $display("FAIL abort_vld: got %b expected 0", vld_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        fill_rom(16'h0000);
        test_reset();
        test_basic();
        test_channels();
        test_saturation();
        test_zero_mac();
        test_overrun();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
